// File: rtl/anton_neopixel_pkg.sv
// Shared definitions for the NeoPixel sequencer: FSM state encoding,
// default timing constants and a constant-evaluable ceil(log2) helper.
package anton_neopixel_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_WAIT  = 3'd2,
        ST_OFFER = 3'd3,
        ST_RESET = 3'd4,
        ST_DONE  = 3'd5
    } np_state_t;

    localparam int unsigned NP_PIXELS_MAX_DEFAULT  = 66;
    // 600 cycles of clk7mhz is roughly 86 us of latch time on the strip.
    localparam int unsigned NP_RESET_DELAY_DEFAULT = 600;

    function automatic int unsigned np_clog2(input int unsigned value);
        int unsigned bits;
        bits = 0;
        while ((64'd1 << bits) < 64'(value)) bits++;
        return bits;
    endfunction

endpackage

// File: rtl/anton_neopixel_reset_timer.sv
// Strip-reset (latch) phase timer: busy for exactly DELAY cycles after a
// start pulse, with a one-cycle done pulse on the final busy cycle.
module anton_neopixel_reset_timer
    import anton_neopixel_pkg::*;
#(
    parameter int unsigned DELAY = NP_RESET_DELAY_DEFAULT
) (
    input  logic clk7mhz,
    input  logic resetN,
    input  logic start,
    input  logic clear,
    output logic busy,
    output logic done
);

    localparam int unsigned CNT_BITS = np_clog2(DELAY + 1);

    logic [CNT_BITS-1:0] count;

    assign done = busy && (count == CNT_BITS'(DELAY - 1));

    always_ff @(posedge clk7mhz or negedge resetN) begin
        if (!resetN) begin
            busy  <= 1'b0;
            count <= '0;
        end else if (clear) begin
            busy  <= 1'b0;
            count <= '0;
        end else if (start) begin
            busy  <= 1'b1;
            count <= '0;
        end else if (done) begin
            busy  <= 1'b0;
            count <= '0;
        end else if (busy) begin
            count <= count + CNT_BITS'(1);
        end
    end

endmodule

// File: rtl/anton_neopixel_sequencer.sv
// Walks the pixel buffer, hands each byte to the serializer with a
// valid/ready handshake, then holds the strip in reset to latch the frame.
module anton_neopixel_sequencer
    import anton_neopixel_pkg::*;
#(
    parameter  int unsigned PIXELS_MAX  = NP_PIXELS_MAX_DEFAULT,
    parameter  int unsigned RESET_DELAY = NP_RESET_DELAY_DEFAULT,
    localparam int unsigned PIXELS_BITS = np_clog2(PIXELS_MAX)
) (
    input  logic                   clk7mhz,
    input  logic                   resetN,
    input  logic                   ctrlRun,
    input  logic                   ctrlLoop,
    input  logic                   ctrlLimit,
    input  logic                   ctrlInit,
    input  logic [15:0]            regMax,
    output logic [PIXELS_BITS-1:0] pixelAddr,
    output logic                   pixelRead,
    input  logic [7:0]             pixelData,
    output logic                   pixelValid,
    input  logic                   pixelReady,
    output logic [7:0]             pixelValue,
    output logic                   stateReset,
    output logic                   stateOff,
    output logic                   frameDone
);

    localparam logic [PIXELS_BITS-1:0] LAST_MAX = PIXELS_BITS'(PIXELS_MAX - 1);

    np_state_t              state, state_next;
    logic [PIXELS_BITS-1:0] index, index_next;
    logic [PIXELS_BITS-1:0] last_idx, last_next;
    logic [PIXELS_BITS-1:0] last_sel;
    logic [7:0]             pixel_value;
    logic                   timer_start, timer_clear, timer_busy, timer_done;

    always_comb begin
        last_sel = LAST_MAX;
        if (ctrlLimit && (regMax < 16'(PIXELS_MAX - 1))) begin
            last_sel = regMax[PIXELS_BITS-1:0];
        end
    end

    always_ff @(posedge clk7mhz or negedge resetN) begin
        if (!resetN) begin
            state       <= ST_IDLE;
            index       <= '0;
            last_idx    <= '0;
            pixel_value <= '0;
        end else begin
            state    <= state_next;
            index    <= index_next;
            last_idx <= last_next;
            if (state == ST_WAIT) begin
                pixel_value <= pixelData;
            end
        end
    end

    always_comb begin
        state_next  = state;
        index_next  = index;
        last_next   = last_idx;
        timer_start = 1'b0;
        timer_clear = 1'b0;
        pixelRead   = 1'b0;
        pixelValid  = 1'b0;
        frameDone   = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (ctrlRun) begin
                    state_next = ST_FETCH;
                    index_next = '0;
                    last_next  = last_sel;
                end
            end
            ST_FETCH: begin
                pixelRead  = 1'b1;
                state_next = ST_WAIT;
            end
            ST_WAIT: begin
                state_next = ST_OFFER;
            end
            ST_OFFER: begin
                pixelValid = 1'b1;
                if (pixelReady) begin
                    if (index < last_idx) begin
                        index_next = index + PIXELS_BITS'(1);
                        state_next = ST_FETCH;
                    end else begin
                        index_next  = '0;
                        state_next  = ST_RESET;
                        timer_start = 1'b1;
                    end
                end
            end
            ST_RESET: begin
                if (timer_done) begin
                    frameDone = 1'b1;
                    if (ctrlRun && ctrlLoop) begin
                        state_next = ST_FETCH;
                        last_next  = last_sel;
                    end else begin
                        state_next = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (!ctrlRun) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
        // Abort overrides whatever the state decided this cycle.
        if (ctrlInit) begin
            state_next  = ST_IDLE;
            index_next  = '0;
            timer_start = 1'b0;
            timer_clear = 1'b1;
            frameDone   = 1'b0;
        end
    end

    anton_neopixel_reset_timer #(
        .DELAY(RESET_DELAY)
    ) u_reset_timer (
        .clk7mhz (clk7mhz),
        .resetN  (resetN),
        .start   (timer_start),
        .clear   (timer_clear),
        .busy    (timer_busy),
        .done    (timer_done)
    );

    assign pixelAddr  = index;
    assign pixelValue = pixel_value;
    assign stateReset = timer_busy;
    assign stateOff   = (state == ST_IDLE);

endmodule

// File: tb/tb_anton_neopixel_sequencer.sv
// Randomized self-checking bench for anton_neopixel_sequencer against a
// frame-level model: expected transfer list, latch length and pulse counts.
`timescale 1ns/1ps
module tb_anton_neopixel_sequencer;

    localparam int NPIX  = 66;
    localparam int RDLY  = 600;
    localparam int ABITS = 7;

    logic             clk7mhz    = 1'b0;
    logic             resetN     = 1'b1;
    logic             ctrlRun    = 1'b0;
    logic             ctrlLoop   = 1'b0;
    logic             ctrlLimit  = 1'b0;
    logic             ctrlInit   = 1'b0;
    logic [15:0]      regMax     = '0;
    logic [ABITS-1:0] pixelAddr;
    logic             pixelRead;
    logic [7:0]       pixelData  = '0;
    logic             pixelValid;
    logic             pixelReady = 1'b0;
    logic [7:0]       pixelValue;
    logic             stateReset;
    logic             stateOff;
    logic             frameDone;

    logic [7:0] mem [0:NPIX-1];

    int         n_checks = 0;
    int         n_fail   = 0;
    int         tr_addr[$];
    logic [7:0] tr_val[$];
    int         rst_cycles = 0;
    int         fd_count   = 0;
    bit         rand_ready = 1'b0;

    anton_neopixel_sequencer #(
        .PIXELS_MAX (NPIX),
        .RESET_DELAY(RDLY)
    ) dut (
        .clk7mhz   (clk7mhz),
        .resetN    (resetN),
        .ctrlRun   (ctrlRun),
        .ctrlLoop  (ctrlLoop),
        .ctrlLimit (ctrlLimit),
        .ctrlInit  (ctrlInit),
        .regMax    (regMax),
        .pixelAddr (pixelAddr),
        .pixelRead (pixelRead),
        .pixelData (pixelData),
        .pixelValid(pixelValid),
        .pixelReady(pixelReady),
        .pixelValue(pixelValue),
        .stateReset(stateReset),
        .stateOff  (stateOff),
        .frameDone (frameDone)
    );

    always #5 clk7mhz = ~clk7mhz;

    // Pixel buffer: synchronous read, data one cycle after the strobe.
    always @(posedge clk7mhz) begin
        if (pixelRead) pixelData <= mem[pixelAddr];
    end

    always @(negedge clk7mhz) begin
        if (resetN) begin
            if (pixelValid && pixelReady) begin
                tr_addr.push_back(int'(pixelAddr));
                tr_val.push_back(pixelValue);
            end
            if (stateReset) rst_cycles++;
            if (frameDone)  fd_count++;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int model_last(input bit limit, input int rmax);
        if (!limit) return NPIX - 1;
        return (rmax < NPIX - 1) ? rmax : NPIX - 1;
    endfunction

    task automatic clear_log();
        tr_addr.delete();
        tr_val.delete();
        rst_cycles = 0;
        fd_count   = 0;
    endtask

    task automatic fill_mem();
        foreach (mem[i]) mem[i] = 8'($urandom);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_addr"},   pixelAddr,  0);
        check_eq({tag, "_read"},   pixelRead,  0);
        check_eq({tag, "_valid"},  pixelValid, 0);
        check_eq({tag, "_value"},  pixelValue, 0);
        check_eq({tag, "_sreset"}, stateReset, 0);
        check_eq({tag, "_soff"},   stateOff,   1);
        check_eq({tag, "_fdone"},  frameDone,  0);
    endtask

    task automatic wait_frames(input int n, input int budget);
        int c;
        c = 0;
        while (fd_count < n && c < budget) begin
            @(posedge clk7mhz); #1;
            pixelReady = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
            c++;
        end
        check_eq("frame_complete", fd_count >= n, 1);
    endtask

    task automatic check_frames(input string tag, input int frames, input int last);
        int per;
        per = last + 1;
        check_eq({tag, "_count"}, tr_addr.size(), frames * per);
        for (int i = 0; i < tr_addr.size() && i < frames * per; i++) begin
            check_eq({tag, "_addr"}, tr_addr[i], i % per);
            check_eq({tag, "_val"},  tr_val[i],  mem[i % per]);
        end
        check_eq({tag, "_reset_len"},  rst_cycles, frames * RDLY);
        check_eq({tag, "_frame_done"}, fd_count,   frames);
    endtask

    task automatic check_done_then_release(input string tag);
        pixelReady = 1'b1;
        repeat (5) @(posedge clk7mhz);
        #1;
        check_eq({tag, "_done_off"},   stateOff,   0);
        check_eq({tag, "_done_sres"},  stateReset, 0);
        check_eq({tag, "_done_valid"}, pixelValid, 0);
        ctrlRun = 1'b0;
        @(posedge clk7mhz); #1;
        check_eq({tag, "_idle"}, stateOff, 1);
    endtask

    task automatic start_run(input bit limit, input int rmax, input bit loop);
        @(posedge clk7mhz); #1;
        ctrlLimit  = limit;
        regMax     = 16'(rmax);
        ctrlLoop   = loop;
        pixelReady = 1'b1;
        ctrlRun    = 1'b1;
    endtask

    task automatic run_frame(input string tag, input bit limit, input int rmax,
                             input bit rnd, input bit chk_latency);
        fill_mem();
        clear_log();
        rand_ready = rnd;
        start_run(limit, rmax, 1'b0);
        if (chk_latency) begin
            @(posedge clk7mhz); #1;
            check_eq("lat_e0_read",  pixelRead,  1);
            check_eq("lat_e0_valid", pixelValid, 0);
            @(posedge clk7mhz); #1;
            check_eq("lat_e1_valid", pixelValid, 0);
            @(posedge clk7mhz); #1;
            check_eq("lat_e2_valid", pixelValid, 1);
            check_eq("lat_e2_addr",  pixelAddr,  0);
            check_eq("lat_e2_value", pixelValue, mem[0]);
        end
        wait_frames(1, 3000);
        check_done_then_release(tag);
        check_frames(tag, 1, model_last(limit, rmax));
    endtask

    initial begin
        int         c;
        logic [6:0] sa;
        logic [7:0] sv;

        // Power-on reset and idle hold.
        #3 resetN = 1'b0;
        #20;
        check_reset_outputs("por");
        @(posedge clk7mhz); #1;
        resetN = 1'b1;
        repeat (10) @(posedge clk7mhz);
        #1;
        check_eq("post_reset_idle", stateOff, 1);
        check_eq("post_reset_read", pixelRead, 0);

        // Full frames and limit boundaries.
        run_frame("full",    1'b0, 0,   1'b0, 1'b1);
        run_frame("lim3",    1'b1, 3,   1'b1, 1'b0);
        run_frame("lim200",  1'b1, 200, 1'b1, 1'b0);
        run_frame("lim0",    1'b1, 0,   1'b1, 1'b0);
        run_frame("lim65",   1'b1, 65,  1'b0, 1'b0);

        // Looping: next frame starts fetching address 0 straight after frameDone.
        fill_mem();
        clear_log();
        rand_ready = 1'b0;
        start_run(1'b0, 0, 1'b1);
        c = 0;
        do begin
            @(negedge clk7mhz);
            c++;
        end while (!frameDone && c < 3000);
        check_eq("loop_fd_seen", frameDone, 1);
        @(negedge clk7mhz);
        check_eq("loop_refetch_read", pixelRead, 1);
        check_eq("loop_refetch_addr", pixelAddr, 0);
        @(posedge clk7mhz); #1;
        ctrlLoop = 1'b0;
        wait_frames(2, 3000);
        check_done_then_release("loop");
        check_frames("loop", 2, NPIX - 1);

        // Back-pressure at address 5.
        fill_mem();
        clear_log();
        rand_ready = 1'b0;
        start_run(1'b0, 0, 1'b0);
        c = 0;
        while (pixelAddr != 5 && c < 100) begin
            @(posedge clk7mhz); #1;
            c++;
        end
        pixelReady = 1'b0;
        check_eq("stall_reach", pixelAddr, 5);
        c = 0;
        do begin
            @(negedge clk7mhz);
            c++;
        end while (!pixelValid && c < 10);
        sa = pixelAddr;
        sv = pixelValue;
        check_eq("stall_value", sv, mem[5]);
        for (int i = 0; i < 10; i++) begin
            check_eq("stall_valid", pixelValid, 1);
            check_eq("stall_addr",  pixelAddr,  sa);
            check_eq("stall_hold",  pixelValue, sv);
            @(negedge clk7mhz);
        end
        @(posedge clk7mhz); #1;
        pixelReady = 1'b1;
        wait_frames(1, 3000);
        check_done_then_release("stall");
        check_frames("stall", 1, NPIX - 1);

        // Abort at address 20 while offering.
        fill_mem();
        clear_log();
        start_run(1'b0, 0, 1'b0);
        c = 0;
        while (pixelAddr != 20 && c < 200) begin
            @(posedge clk7mhz); #1;
            c++;
        end
        pixelReady = 1'b0;
        c = 0;
        do begin
            @(negedge clk7mhz);
            c++;
        end while (!pixelValid && c < 10);
        check_eq("init_offer", pixelValid, 1);
        @(posedge clk7mhz); #1;
        ctrlInit = 1'b1;
        ctrlRun  = 1'b0;
        @(posedge clk7mhz); #1;
        ctrlInit = 1'b0;
        check_eq("init_idle",  stateOff,   1);
        check_eq("init_valid", pixelValid, 0);
        check_eq("init_addr",  pixelAddr,  0);
        repeat (RDLY + 100) @(posedge clk7mhz);
        #1;
        check_eq("init_no_fdone",  fd_count,       0);
        check_eq("init_no_sreset", rst_cycles,     0);
        check_eq("init_transfers", tr_addr.size(), 20);
        check_eq("init_still_idle", stateOff,      1);

        // Asynchronous reset in the middle of the latch phase.
        fill_mem();
        clear_log();
        start_run(1'b0, 0, 1'b0);
        c = 0;
        do begin
            @(negedge clk7mhz);
            c++;
        end while (!stateReset && c < 1000);
        check_eq("rst_phase_seen", stateReset, 1);
        repeat (300) @(posedge clk7mhz);
        #2 resetN = 1'b0;
        #1;
        check_reset_outputs("async");
        ctrlRun = 1'b0;
        repeat (3) @(posedge clk7mhz);
        #1 resetN = 1'b1;
        repeat (10) @(posedge clk7mhz);
        #1;
        check_eq("async_idle",     stateOff,   1);
        check_eq("async_sreset",   stateReset, 0);
        check_eq("async_no_fdone", fd_count,   0);

        // Random configurations with random back-pressure.
        for (int k = 0; k < 4; k++) begin
            run_frame("rand", 1'($urandom_range(0, 1)), int'($urandom_range(0, 80)), 1'b1, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
